// File: rtl/p_neg_arb.sv
// p_neg_arb: round-robin arbiter in front of one shared saturating negation
// datapath. One result register; a grant is only issued when that register
// is empty or being drained, giving one result per cycle when the consumer
// keeps up.

package p_neg_arb_pkg;
    typedef enum logic [1:0] {FXP = 2'd0, FLT = 2'd1} dtype_e;
    typedef enum logic {Disable = 1'b0, Enable = 1'b1} sign_e;
    typedef struct packed {
        dtype_e     dtype;
        sign_e      sign;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;
endpackage

module p_neg_arb
    import p_neg_arb_pkg::*;
#(
    parameter dconf_t CONF = '{dtype: FXP, sign: Enable, prec: 8'd8, frac: 8'd3},
    parameter int NREQ = 4,
    parameter int CNTW = 16,
    localparam int PREC = int'(CONF.prec),
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*PREC-1:0] req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PREC-1:0]      out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_sat,
    input  logic                 sat_clr,
    output logic [CNTW-1:0]      sat_cnt
);

    localparam logic [PREC-1:0] MOST_NEG = {1'b1, {(PREC-1){1'b0}}};
    localparam logic [PREC-1:0] MAX_POS  = {1'b0, {(PREC-1){1'b1}}};

    logic [IDW-1:0]  r_rr_ptr;
    logic            r_out_valid;
    logic [PREC-1:0] r_out_data;
    logic [IDW-1:0]  r_out_id;
    logic            r_out_sat;
    logic [CNTW-1:0] r_sat_cnt;

    logic            w_req_hit;
    logic [IDW-1:0]  w_gidx;
    logic [IDW:0]    w_sum;
    logic            w_can_grant;
    logic            w_do_grant;
    logic            w_accept;
    logic [IDW-1:0]  w_next_ptr;
    logic [PREC-1:0] w_opnd;
    logic [PREC-1:0] w_neg;
    logic            w_neg_sat;

    assign w_can_grant = !r_out_valid || out_ready;
    assign w_do_grant  = reset_ && w_can_grant && w_req_hit;
    assign w_accept    = r_out_valid && out_ready;
    assign w_next_ptr  = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    assign w_opnd      = req_data[int'(w_gidx) * PREC +: PREC];

    // Round-robin search from r_rr_ptr; scanning farthest-first lets the
    // nearest active requester win by being the last assignment.
    always_comb begin
        w_req_hit = 1'b0;
        w_gidx    = '0;
        w_sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (req[w_sum[IDW-1:0]]) begin
                w_req_hit = 1'b1;
                w_gidx    = w_sum[IDW-1:0];
            end
        end
    end

    // One-hot acknowledge for the granted requester.
    always_comb begin
        ack = '0;
        if (w_do_grant) begin
            ack[w_gidx] = 1'b1;
        end
    end

    // Saturating negation; the fractional position does not affect the bits.
    always_comb begin
        w_neg     = '0;
        w_neg_sat = 1'b0;
        if (CONF.sign == Enable) begin
            if (w_opnd == MOST_NEG) begin
                w_neg     = MAX_POS;
                w_neg_sat = 1'b1;
            end else begin
                w_neg = -w_opnd;
            end
        end else begin
            w_neg_sat = |w_opnd;
        end
    end

    // Result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_do_grant) begin
            r_rr_ptr    <= w_next_ptr;
            r_out_valid <= 1'b1;
            r_out_data  <= w_neg;
            r_out_id    <= w_gidx;
            r_out_sat   <= w_neg_sat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count of accepted saturated results; clear wins, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_accept && r_out_sat && (r_sat_cnt != {CNTW{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_p_neg_arb.sv
// Directed and randomized checks for p_neg_arb (4 requesters, 8-bit signed,
// 3-bit saturation counter so that counter saturation is reachable).

module tb_p_neg_arb;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           reset_;
    logic [N-1:0]   req;
    logic [N*P-1:0] req_data;
    logic [N-1:0]   ack;
    logic           out_valid;
    logic           out_ready;
    logic [P-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_sat;
    logic           sat_clr;
    logic [CW-1:0]  sat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]   m_dat [N];
    logic         m_pend [N];
    int           m_ptr;
    logic         m_ov;
    logic [7:0]   m_od;
    int           m_oid;
    logic         m_os;
    int           m_cnt;
    int           g;
    int           j;
    int           r;
    int           n_ops;
    int           n_acks;
    logic [N-1:0] e_ack;
    logic [7:0]   exp8;

    p_neg_arb #(.NREQ(N), .CNTW(CW)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_sat   (out_sat),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {sat, data} of the saturated two's complement negation
    function automatic logic [8:0] ref_neg(input logic [7:0] x);
        int v;
        v = -int'($signed(x));
        if (v > 127) return {1'b1, 8'h7F};
        return {1'b0, 8'(v)};
    endfunction

    initial begin
        reset_    = 1'b0;
        req       = '0;
        req_data  = '0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        tick();

        // reset: no ack even with all requesters active and a free result register
        req = 4'hF;
        #1;
        check_val("rst_ack", 32'(ack), 32'h0);
        tick();
        check_val("rst_valid", 32'(out_valid), 32'h0);
        check_val("rst_data", 32'(out_data), 32'h0);
        check_val("rst_id", 32'(out_id), 32'h0);
        check_val("rst_sat", 32'(out_sat), 32'h0);
        check_val("rst_cnt", 32'(sat_cnt), 32'h0);

        // 3.5 -> -3.5
        reset_   = 1'b1;
        req      = 4'b0001;
        req_data = 32'h0000_001C;
        #1;
        check_val("t1_ack", 32'(ack), 32'h1);
        tick();
        check_val("t1_valid", 32'(out_valid), 32'h1);
        check_val("t1_data", 32'(out_data), 32'hE4);
        check_val("t1_id", 32'(out_id), 32'h0);
        check_val("t1_sat", 32'(out_sat), 32'h0);

        // 15.5 -> -15.5, then most-negative saturates
        req      = 4'b0010;
        req_data = 32'h0000_7C00;
        #1;
        check_val("t2_ack", 32'(ack), 32'h2);
        tick();
        check_val("t2_data", 32'(out_data), 32'h84);
        check_val("t2_id", 32'(out_id), 32'h1);
        req_data = 32'h0000_8000;
        #1;
        check_val("t2b_ack", 32'(ack), 32'h2);
        tick();
        check_val("t2b_data", 32'(out_data), 32'h7F);
        check_val("t2b_sat", 32'(out_sat), 32'h1);
        req = '0;
        tick();
        check_val("t2b_cnt", 32'(sat_cnt), 32'h1);
        check_val("t2b_drained", 32'(out_valid), 32'h0);

        // all requesters held: rotation from index 0 without idle cycles
        reset_ = 1'b0;
        tick();
        reset_   = 1'b1;
        req      = 4'hF;
        req_data = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val("rr_ack", 32'(ack), 32'(1 << (i % 4)));
            tick();
            exp8 = 8'(-((i % 4) + 1));
            check_val("rr_valid", 32'(out_valid), 32'h1);
            check_val("rr_id", 32'(out_id), 32'(i % 4));
            check_val("rr_data", 32'(out_data), 32'(exp8));
        end

        // backpressure: no grant, result held
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("bp_ack", 32'(ack), 32'h0);
            tick();
            check_val("bp_valid", 32'(out_valid), 32'h1);
            check_val("bp_id", 32'(out_id), 32'h3);
            check_val("bp_data", 32'(out_data), 32'hFC);
            check_val("bp_sat", 32'(out_sat), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_rel_ack", 32'(ack), 32'h1);
        tick();
        check_val("bp_rel_id", 32'(out_id), 32'h0);
        check_val("bp_rel_data", 32'(out_data), 32'hFF);

        // sat_clr coinciding with a saturated accept
        req      = 4'b0001;
        req_data = 32'h0000_0080;
        #1;
        check_val("sc_ack1", 32'(ack), 32'h1);
        tick();
        check_val("sc_sat1", 32'(out_sat), 32'h1);
        check_val("sc_cnt0", 32'(sat_cnt), 32'h0);
        #1;
        check_val("sc_ack2", 32'(ack), 32'h1);
        tick();
        check_val("sc_cnt1", 32'(sat_cnt), 32'h1);
        req     = '0;
        sat_clr = 1'b1;
        tick();
        check_val("sc_cnt_clr", 32'(sat_cnt), 32'h0);
        check_val("sc_valid", 32'(out_valid), 32'h0);
        sat_clr = 1'b0;

        // reset while a result is held
        req      = 4'b0010;
        req_data = 32'h0000_1000;
        #1;
        check_val("mr_ack", 32'(ack), 32'h2);
        tick();
        check_val("mr_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b0;
        reset_    = 1'b0;
        req       = 4'hF;
        #1;
        check_val("mr_rst_ack", 32'(ack), 32'h0);
        tick();
        check_val("mr_rst_valid", 32'(out_valid), 32'h0);
        check_val("mr_rst_data", 32'(out_data), 32'h0);
        reset_    = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val("mr_ptr0_ack", 32'(ack), 32'h1);
        tick();
        check_val("mr_ptr0_id", 32'(out_id), 32'h0);

        // randomized traffic against the reference model
        reset_ = 1'b0;
        req    = '0;
        tick();
        reset_ = 1'b1;
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_od   = '0;
        m_oid  = 0;
        m_os   = 1'b0;
        m_cnt  = 0;
        n_ops  = 0;
        n_acks = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_dat[i]  = '0;
        end
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_pend[i]) begin
                    if ($urandom_range(2) == 0) begin
                        m_pend[i] = 1'b1;
                        r = int'($urandom_range(7));
                        m_dat[i] = (r == 0) ? 8'h80 : (r == 1) ? 8'h00 : 8'($urandom);
                    end
                end else if ($urandom_range(19) == 0) begin
                    m_pend[i] = 1'b0;
                end
                req[i]          = m_pend[i];
                req_data[i*P +: P] = m_dat[i];
            end
            out_ready = ($urandom_range(3) != 0);
            sat_clr   = ($urandom_range(31) == 0);
            #1;
            g = -1;
            if (!m_ov || out_ready) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && m_pend[j]) g = j;
                end
            end
            e_ack = '0;
            if (g >= 0) e_ack[g] = 1'b1;
            check_val("rnd_ack", 32'(ack), 32'(e_ack));
            check_val("rnd_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                check_val("rnd_data", 32'(out_data), 32'(m_od));
                check_val("rnd_id", 32'(out_id), 32'(m_oid));
                check_val("rnd_sat", 32'(out_sat), 32'(m_os));
            end
            check_val("rnd_cnt", 32'(sat_cnt), 32'(m_cnt));
            n_acks += $countones(ack);
            if (sat_clr) m_cnt = 0;
            else if (m_ov && out_ready && m_os && m_cnt < 7) m_cnt++;
            if (g >= 0) begin
                {m_os, m_od} = ref_neg(m_dat[g]);
                m_oid     = g;
                m_ov      = 1'b1;
                m_pend[g] = 1'b0;
                m_ptr     = (g + 1) % N;
                n_ops++;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            tick();
        end
        check_val("rnd_ack_total", 32'(n_acks), 32'(n_ops));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/p_neg_arb.md
P_NEG_ARB -- requirements
Module: p_neg_arb

Interface
REQ-001 Parameter CONF, dconf_t, default {dtype: FXP, sign: Enable, prec: 8, frac: 3}; data format of every operand and result.
REQ-002 Parameter NREQ, default 4; number of requesters sharing one negation datapath; legal range 2..8.
REQ-003 Parameter CNTW, default 16; width of the saturation-event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 req  input  NREQ  per-requester operand-valid; held high until acknowledged.
REQ-007 req_data  input  NREQ*PREC  per-requester operand; slice i = bits [i*PREC +: PREC].
REQ-008 ack  output  NREQ  one-hot acknowledge; single-cycle pulse, operand consumed this cycle.
REQ-009 out_valid  output  1  result register holds a valid result.
REQ-010 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-011 out_data  output  PREC  negated operand, saturated to format range.
REQ-012 out_id  output  $clog2(NREQ)  index of requester that produced out_data.
REQ-013 out_sat  output  1  result was saturated.
REQ-014 sat_clr  input  1  synchronous clear of sat_cnt.
REQ-015 sat_cnt  output  CNTW  count of saturated results accepted by the consumer.

Function
REQ-016 Arbitration: round-robin over req, starting the search at pointer rr_ptr and wrapping from NREQ-1 to 0.
REQ-017 Grant condition: a grant is issued only when the result register is empty or is drained in the same cycle (out_valid && out_ready). This gives back-to-back throughput of one result per cycle.
REQ-018 On grant to index g: ack[g]=1 that cycle, and rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
REQ-019 ack shall be zero whenever no grant is issued, and shall never have more than one bit set.
REQ-020 Latency: the result for operand granted in cycle n appears with out_valid=1 in cycle n+1.
REQ-021 Result register holds out_data, out_id and out_sat stable while out_valid && !out_ready.
REQ-022 out_valid clears after a drain cycle with no new grant.
REQ-023 Signed negation (sign=Enable): out_data = -x in two's complement.
REQ-024 Signed, x = most-negative value (1 followed by PREC-1 zeros): out_data = max positive (0 followed by PREC-1 ones) and out_sat=1.
REQ-025 Unsigned negation (sign=Disable): x=0 gives out_data=0, out_sat=0; any x!=0 gives out_data=0, out_sat=1.
REQ-026 FRAC does not alter the bit-level operation. Negation is exact except at the saturation points above.
REQ-027 sat_cnt increments by 1 on each accepted transfer with out_sat=1, and saturates at all-ones (no wrap).
REQ-028 sat_clr has priority over increment: if both occur in the same cycle, sat_cnt becomes 0.
REQ-029 A requester deasserting req before ack is legal and removes it from arbitration that cycle.
REQ-030 req_data is sampled only in the ack cycle.

Reset
REQ-031 When reset_=0 at a clock edge: out_valid=0, out_data=0, out_id=0, out_sat=0, rr_ptr=0, sat_cnt=0.
REQ-032 ack shall be 0 in every cycle where reset_=0, regardless of req.
REQ-033 Reset mid-transfer discards any held result; no ack is issued in the reset cycle.
REQ-034 After reset release, arbitration restarts from index 0.

Verification
REQ-035 Bench shall cover: req=0001, data0=8'b00011_100 (3.5), out_ready=1 -> ack=0001; next cycle out_valid=1, out_data=8'b11100_100 (-3.5), out_id=0, out_sat=0.
REQ-036 Bench shall cover: req=0010, data1=8'h7C (15.5) -> out_data=8'h84, out_id=1; then data1=8'h80 -> out_data=8'h7F, out_sat=1, sat_cnt=1 after accept.
REQ-037 Bench shall cover: req=1111 held, out_ready=1 for 8 cycles -> ack sequence 0001,0010,0100,1000,0001,...; out_id sequence 0,1,2,3,0,...; no idle cycles.
REQ-038 Bench shall cover: out_valid=1 with out_ready=0 for 5 cycles while req=1111 -> ack=0 and outputs stable throughout; on out_ready=1, the next grant occurs the same cycle.
REQ-039 Bench shall cover: sat_clr asserted in the same cycle as a saturated accept -> sat_cnt=0; and reset_=0 while out_valid=1 -> out_valid=0 and rr_ptr=0 on the next cycle.
REQ-040 Bench shall cover: 1000 random cycles of req, data and out_ready checked against a reference model. Every result shall equal the saturated negation of its operand, and no operand shall be lost or duplicated.
